// File: rtl/lsu_master.sv
// lsu_master
//   Load/store sequencer for the MEM stage. It takes one access from the
//   pipeline, checks its alignment and range, and then runs word-aligned
//   transactions on a word-only data memory. SB/SH are done as
//   read-modify-write. Load results come back sign- or zero-extended.
//
// Ports
//   clk, Reset        clock; synchronous active-high reset
//   req_valid/ready   pipeline handshake (ready only when idle)
//   req_op            0 LW, 1 LBU, 2 LB, 3 LHU, 4 LH, 5 SW, 6 SB, 7 SH
//   req_addr/wdata    byte address and store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores/exceptions)
//   resp_exc          address error; resp_badaddr holds the faulting address
//   mem_req/we        memory transaction active / write enable
//   mem_addr/wdata    word address and write word (0 while mem_req=0)
//   mem_ready/rdata   memory completion and read data
//
// state | meaning
// IDLE  | waiting for an access; req_ready=1
// RD    | word read in progress (loads, and the read half of SB/SH)
// WR    | word write in progress (SW, and the write half of SB/SH)
// RESP  | one-cycle response pulse
module lsu_master #(
    parameter int unsigned DM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [31:0] resp_badaddr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LH  = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_n;
    logic [2:0]  op_q, op_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] data_q, data_n;     // store data, replaced by the merged word for SB/SH
    logic [31:0] rdata_q, rdata_n;
    logic        exc_q, exc_n;
    logic [31:0] badaddr_q, badaddr_n;
    logic        misaligned;
    logic        out_of_range;

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LBU:  r = {24'b0, b};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LHU:  r = {16'b0, h};
            OP_LH:   r = {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] a,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        if (op == OP_SB)
            r[{a, 3'b000} +: 8] = wd[7:0];
        else if (a[1])
            r[31:16] = wd[15:0];
        else
            r[15:0] = wd[15:0];
        return r;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (req_addr >= 32'(DM_BYTES));

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            exc_q     <= 1'b0;
            badaddr_q <= '0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            rdata_q   <= rdata_n;
            exc_q     <= exc_n;
            badaddr_q <= badaddr_n;
        end
    end

    // Response fields default to 0 every cycle, so they are only non-zero
    // during the single RESP cycle that follows the cycle that loaded them.
    always_comb begin
        state_n   = state;
        op_n      = op_q;
        addr_n    = addr_q;
        data_n    = data_q;
        rdata_n   = '0;
        exc_n     = 1'b0;
        badaddr_n = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_n   = req_op;
                    addr_n = req_addr;
                    data_n = req_wdata;
                    if (misaligned || out_of_range) begin
                        state_n   = RESP;
                        exc_n     = 1'b1;
                        badaddr_n = req_addr;
                    end else if (req_op == OP_SW) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (mem_ready) begin
                    if (op_q == OP_SB || op_q == OP_SH) begin
                        data_n  = store_merge(op_q, addr_q[1:0], mem_rdata, data_q);
                        state_n = WR;
                    end else begin
                        rdata_n = load_extract(op_q, addr_q[1:0], mem_rdata);
                        state_n = RESP;
                    end
                end
            end
            WR: begin
                if (mem_ready)
                    state_n = RESP;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign resp_rdata   = rdata_q;
    assign resp_exc     = exc_q;
    assign resp_badaddr = badaddr_q;
    assign mem_req      = (state == RD) || (state == WR);
    assign mem_we       = (state == WR);
    assign mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata    = (state == WR) ? data_q : 32'h0;

endmodule
